// File: rtl/io_uart_tx_buffer_pkg.sv
// Shared constants for the UART TX buffer: decoded IO addresses, serializer
// state encodings and frame geometry.
package io_uart_tx_buffer_pkg;

  localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0] IO_HALT_ADDR = 18'h30004;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Start bit + 8 data bits + stop bit.
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/io_uart_tx_buffer_if.sv
// CPU-side write bus into the UART TX buffer, plus its back-pressure signal.
interface io_uart_tx_buffer_if;

  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (output rdy_in, output mem_a, output mem_dout, output mem_wr,
                  input  io_buffer_full);
  modport slave  (input  rdy_in, input  mem_a, input  mem_dout, input  mem_wr,
                  output io_buffer_full);

endinterface

// File: rtl/io_uart_tx_buffer_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when
// empty are ignored.
module sync_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [DEPTH_WIDTH:0]   count,
  output logic                   full,
  output logic                   empty
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count == (DEPTH_WIDTH + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; count and the pointers
  // define which entries are valid, and an unreset array can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx_buffer.sv
// Memory-mapped UART output: captures CPU byte writes into a FIFO, drains it
// as 8N1 frames on uart_tx, and latches the program-end write as halt_seen.
module io_uart_tx_buffer
  import io_uart_tx_buffer_pkg::*;
#(
  parameter int FIFO_DEPTH_WIDTH = 4,
  parameter int FULL_MARGIN      = 2,
  parameter int CLK_PER_BIT      = 868
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  io_uart_tx_buffer_if.slave    bus,
  output logic                  uart_tx,
  output logic                  tx_busy,
  output logic                  overflow,
  output logic                  halt_seen
);

  localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_WIDTH:0] FULL_LEVEL =
    (FIFO_DEPTH_WIDTH + 1)'((1 << FIFO_DEPTH_WIDTH) - FULL_MARGIN);

  logic                      cpu_wr;
  logic                      push;
  logic                      halt_wr;
  logic                      pop;
  logic [7:0]                fifo_dout;
  logic [FIFO_DEPTH_WIDTH:0] fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      unused_addr_hi;

  logic [1:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              bit_end;

  // Only the low 18 address bits are decoded.
  assign unused_addr_hi = ^bus.mem_a[31:18];
  assign cpu_wr  = bus.rdy_in & bus.mem_wr;
  assign push    = cpu_wr & (bus.mem_a[17:0] == IO_DATA_ADDR);
  assign halt_wr = cpu_wr & (bus.mem_a[17:0] == IO_HALT_ADDR);

  sync_fifo #(
    .WIDTH       (8),
    .DEPTH_WIDTH (FIFO_DEPTH_WIDTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .push  (push),
    .pop   (pop),
    .din   (bus.mem_dout),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.io_buffer_full = (fifo_count >= FULL_LEVEL);
  assign tx_busy            = (state != ST_IDLE) | ~fifo_empty;

  // Popping at the end of a stop bit chains frames with no idle gap.
  assign bit_end = (baud_cnt == '0);
  assign pop     = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else if (pop) begin
      state    <= ST_START;
      shreg    <= fifo_dout;
      baud_cnt <= BAUD_LAST;
      uart_tx  <= 1'b0;
    end else begin
      case (state)
        ST_START: begin
          if (bit_end) begin
            state    <= ST_DATA;
            bit_idx  <= '0;
            baud_cnt <= BAUD_LAST;
            uart_tx  <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_LAST;
            if (bit_idx == 3'd7) begin
              state   <= ST_STOP;
              uart_tx <= 1'b1;
            end else begin
              shreg   <= shreg >> 1;
              uart_tx <= shreg[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) state <= ST_IDLE;
          else         baud_cnt <= baud_cnt - 1'b1;
          uart_tx <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overflow  <= 1'b0;
      halt_seen <= 1'b0;
    end else begin
      overflow  <= overflow | (push & fifo_full);
      halt_seen <= halt_seen | halt_wr;
    end
  end

endmodule

// File: tb/tb_io_uart_tx_buffer.sv
// Bench for io_uart_tx_buffer: a frame-level model (byte queue plus a frame
// timer) is compared with the DUT on every falling edge, plus directed checks.
module tb_io_uart_tx_buffer;
  import io_uart_tx_buffer_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = UART_FRAME_BITS * CPB;

  logic clk;
  logic rst_n;
  logic uart_tx;
  logic tx_busy;
  logic overflow;
  logic halt_seen;

  io_uart_tx_buffer_if bus();

  io_uart_tx_buffer #(
    .FIFO_DEPTH_WIDTH (4),
    .FULL_MARGIN      (2),
    .CLK_PER_BIT      (CPB)
  ) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .bus       (bus),
    .uart_tx   (uart_tx),
    .tx_busy   (tx_busy),
    .overflow  (overflow),
    .halt_seen (halt_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes waiting in the FIFO, the byte on the line and the cycles
  // left in its frame (0 = line idle).
  logic [7:0] m_q[$];
  logic [7:0] popped[$];
  logic [7:0] m_cur;
  int         m_t;
  logic       m_ovf;
  logic       m_halt;

  initial begin
    int   pre;
    logic wr;
    m_t = 0; m_ovf = 0; m_halt = 0; m_cur = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_t = 0; m_ovf = 0; m_halt = 0;
      end else begin
        pre = m_q.size();
        wr  = bus.rdy_in & bus.mem_wr;
        if (m_t > 0) m_t--;
        if (m_t == 0 && m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          popped.push_back(m_cur);
          m_t = FRAME;
        end
        if (wr && bus.mem_a[17:0] == IO_DATA_ADDR) begin
          if (pre == DEPTH) m_ovf = 1'b1;
          else              m_q.push_back(bus.mem_dout);
        end
        if (wr && bus.mem_a[17:0] == IO_HALT_ADDR) m_halt = 1'b1;
      end
    end
  end

  function automatic logic exp_tx();
    int b;
    if (m_t == 0) return 1'b1;
    b = (FRAME - m_t) / CPB;
    if (b == 0) return 1'b0;
    if (b == UART_FRAME_BITS - 1) return 1'b1;
    return m_cur[b-1];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      check("uart_tx",        uart_tx,            exp_tx());
      check("io_buffer_full", bus.io_buffer_full, m_q.size() >= DEPTH - 2);
      check("tx_busy",        tx_busy,            (m_t > 0) || (m_q.size() > 0));
      check("overflow",       overflow,           m_ovf);
      check("halt_seen",      halt_seen,          m_halt);
    end
  end

  task automatic bus_cycle(input logic rdy, input logic wr, input logic [31:0] a,
                           input logic [7:0] d);
    @(negedge clk);
    bus.rdy_in = rdy; bus.mem_wr = wr; bus.mem_a = a; bus.mem_dout = d;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.mem_wr = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((tx_busy || m_t > 0 || m_q.size() > 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", tx_busy, 1'b0);
  endtask

  initial begin
    logic [9:0]  pat;
    logic [31:0] addr;
    bus.rdy_in = 1'b1; bus.mem_wr = 1'b0; bus.mem_a = '0; bus.mem_dout = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (100) @(negedge clk);
    check("idle_tx",   uart_tx,            1'b1);
    check("idle_full", bus.io_buffer_full, 1'b0);
    check("idle_busy", tx_busy,            1'b0);

    // Single 0x55 frame: start bit one edge after the capture edge.
    bus_cycle(1'b1, 1'b1, 32'h0003_0000, 8'h55);
    idle();
    check("frame55_pre", uart_tx, 1'b1);
    pat = 10'b10_1010_1010;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      if (j % CPB == 2) check("frame55_bit", uart_tx, pat[j / CPB]);
    end
    wait_drain();

    // Burst of 16 bytes: almost-full threshold and ordering.
    popped.delete();
    for (int i = 0; i < 16; i++) begin
      bus_cycle(1'b1, 1'b1, 32'h0003_0000, 8'(i));
      if (i > 0) check("burst_full", bus.io_buffer_full, (i - 1) >= 14);
    end
    idle();
    wait_drain();
    check("burst_count", popped.size(), 16);
    for (int i = 0; i < 16 && i < popped.size(); i++) check("burst_order", popped[i], i);
    check("burst_ovf", overflow, 1'b0);

    // Burst of 18 bytes: the 18th arrives while full and is dropped.
    popped.delete();
    for (int i = 0; i < 18; i++) bus_cycle(1'b1, 1'b1, 32'h0003_0000, 8'(8'h80 + i));
    idle();
    check("ovf_set", overflow, 1'b1);
    wait_drain();
    check("ovf_count", popped.size(), 17);
    if (popped.size() == 17) check("ovf_last", popped[16], 8'h90);

    // Halt writes honour rdy_in and leave the FIFO alone.
    bus_cycle(1'b0, 1'b1, 32'h0003_0004, 8'h77);
    idle();
    check("halt_rdy0", halt_seen, 1'b0);
    bus_cycle(1'b1, 1'b1, 32'h0003_0004, 8'h77);
    idle();
    check("halt_rdy1", halt_seen, 1'b1);
    check("halt_fifo", tx_busy, 1'b0);

    // Random traffic across data, halt and unrelated addresses.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 4))
        0:       addr = 32'h0003_0000;
        1:       addr = {14'($urandom), 18'h30000};
        2:       addr = 32'h0003_0004;
        3:       addr = 32'h0003_0001;
        default: addr = 32'h0002_0000;
      endcase
      bus_cycle($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 60, addr, 8'($urandom));
    end
    idle();
    wait_drain();

    // Async reset in the middle of data bit 0 of 0xF0.
    for (int i = 0; i < 3; i++) bus_cycle(1'b1, 1'b1, 32'h0003_0000, 8'(8'hF0 + i));
    idle();
    repeat (4) @(posedge clk);
    #2;
    check("rst_pre_tx", uart_tx, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_tx",   uart_tx,   1'b1);
    check("rst_busy", tx_busy,   1'b0);
    check("rst_ovf",  overflow,  1'b0);
    check("rst_halt", halt_seen, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    popped.delete();
    bus_cycle(1'b1, 1'b1, 32'h0003_0000, 8'hA5);
    idle();
    wait_drain();
    check("post_rst_count", popped.size(), 1);
    if (popped.size() == 1) check("post_rst_byte", popped[0], 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
